// File: rtl/elevator_request_scheduler.sv
// Four-floor elevator controller: latches floor calls and serves them in SCAN order.
// Outputs and the outstanding-call vector are all registered.
module elevator_request_scheduler #(
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] call_req,
   input  logic       extra_waiting,
   output logic       move_up,
   output logic       move_down,
   output logic       door_open,
   output logic [1:0] state_output,
   output logic [1:0] current_floor,
   output logic [3:0] pending
);

   localparam int TW = $clog2(TRAVEL_CYCLES);
   localparam int DW = $clog2(DOOR_CYCLES);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

   localparam logic [1:0] IDLE        = 2'b00;
   localparam logic [1:0] MOVING_UP   = 2'b01;
   localparam logic [1:0] MOVING_DOWN = 2'b10;
   localparam logic [1:0] DOOR_OPEN   = 2'b11;

   logic [1:0]    state, state_next;
   logic [1:0]    floor_next, new_floor;
   logic [3:0]    pending_next, set_mask, clear_mask;
   logic          last_dir, dir_next, going_up;
   logic [TW-1:0] travel_cnt, travel_next;
   logic [DW-1:0] door_cnt, door_next;
   logic          calls_above, calls_below;

   // Floors strictly beyond f in the given direction.
   function automatic logic [3:0] beyond(input logic [1:0] f, input logic up);
      logic [3:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[i] = up ? (i > int'(f)) : (i < int'(f));
      end
      return m;
   endfunction

   assign calls_above  = |(pending & beyond(current_floor, 1'b1));
   assign calls_below  = |(pending & beyond(current_floor, 1'b0));
   assign state_output = state;

   always_comb begin
      state_next  = state;
      floor_next  = current_floor;
      dir_next    = last_dir;
      travel_next = travel_cnt;
      door_next   = door_cnt;
      set_mask    = call_req;
      clear_mask  = '0;
      new_floor   = current_floor;
      going_up    = (state == MOVING_UP);

      case (state)
         IDLE: begin
            if (pending[current_floor]) begin
               state_next                = DOOR_OPEN;
               clear_mask[current_floor] = 1'b1;
               door_next                 = '0;
            end else if ((last_dir && calls_above) || (!last_dir && !calls_below && calls_above)) begin
               state_next  = MOVING_UP;
               dir_next    = 1'b1;
               travel_next = '0;
            end else if (calls_below) begin
               state_next  = MOVING_DOWN;
               dir_next    = 1'b0;
               travel_next = '0;
            end
         end

         MOVING_UP, MOVING_DOWN: begin
            if (travel_cnt == TRAVEL_LAST) begin
               travel_next = '0;
               new_floor   = going_up ? current_floor + 2'd1 : current_floor - 2'd1;
               floor_next  = new_floor;
               if (pending[new_floor]) begin
                  state_next            = DOOR_OPEN;
                  clear_mask[new_floor] = 1'b1;
                  door_next             = '0;
               end else if (!(|(pending & beyond(new_floor, going_up)))) begin
                  state_next = IDLE;
               end
            end else begin
               travel_next = travel_cnt + 1'b1;
            end
         end

         default: begin
            // A call for the floor the door is open at just keeps the door open.
            set_mask[current_floor] = 1'b0;
            if (extra_waiting || call_req[current_floor]) begin
               door_next = '0;
            end else if (door_cnt == DOOR_LAST) begin
               state_next = IDLE;
            end else begin
               door_next = door_cnt + 1'b1;
            end
         end
      endcase

      pending_next = (pending | set_mask) & ~clear_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         current_floor <= 2'd0;
         pending       <= 4'd0;
         last_dir      <= 1'b1;
         travel_cnt    <= '0;
         door_cnt      <= '0;
         move_up       <= 1'b0;
         move_down     <= 1'b0;
         door_open     <= 1'b0;
      end else begin
         state         <= state_next;
         current_floor <= floor_next;
         pending       <= pending_next;
         last_dir      <= dir_next;
         travel_cnt    <= travel_next;
         door_cnt      <= door_next;
         move_up       <= (state_next == MOVING_UP);
         move_down     <= (state_next == MOVING_DOWN);
         door_open     <= (state_next == DOOR_OPEN);
      end
   end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler; expected values are hand-derived
// cycle by cycle from TRAVEL_CYCLES=4 and DOOR_CYCLES=3.
module tb_elevator_request_scheduler;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_UP   = 2'b01;
   localparam logic [1:0] S_DOWN = 2'b10;
   localparam logic [1:0] S_DOOR = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] call_req;
   logic       extra_waiting;
   logic       move_up, move_down, door_open;
   logic [1:0] state_output, current_floor;
   logic [3:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   elevator_request_scheduler #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .call_req      (call_req),
      .extra_waiting (extra_waiting),
      .move_up       (move_up),
      .move_down     (move_down),
      .door_open     (door_open),
      .state_output  (state_output),
      .current_floor (current_floor),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Direction/door flags are expected to be a one-hot decode of the state.
   task automatic check_output(input string tag, input logic [1:0] exp_state,
                               input logic [1:0] exp_floor, input logic [3:0] exp_pend);
      logic [10:0] obs, exp;
      obs = {move_up, move_down, door_open, state_output, current_floor, pending};
      exp = {exp_state == S_UP, exp_state == S_DOWN, exp_state == S_DOOR,
             exp_state, exp_floor, exp_pend};
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %b expected %b (up,down,door,state,floor,pending)",
                tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      call_req = 4'b0000;
      extra_waiting = 1'b0;
      #1 check_output("reset_hold", S_IDLE, 2'd0, 4'b0000);
      tick(2);
      reset = 1'b0;
      tick(1);
      check_output("post_reset", S_IDLE, 2'd0, 4'b0000);

      // Call at the current floor: latched one edge, door the next, open 3 cycles.
      call_req = 4'b0001;
      tick(1); call_req = 4'b0000;
      check_output("f0_latched", S_IDLE, 2'd0, 4'b0001);
      tick(1); check_output("f0_door_1", S_DOOR, 2'd0, 4'b0000);
      tick(1); check_output("f0_door_2", S_DOOR, 2'd0, 4'b0000);
      tick(1); check_output("f0_door_3", S_DOOR, 2'd0, 4'b0000);
      tick(1); check_output("f0_closed", S_IDLE, 2'd0, 4'b0000);

      // Run from floor 0 to floor 3.
      call_req = 4'b1000;
      tick(1); call_req = 4'b0000;
      check_output("up3_latched", S_IDLE, 2'd0, 4'b1000);
      tick(1); check_output("up3_start", S_UP, 2'd0, 4'b1000);
      tick(3); check_output("up3_still_f0", S_UP, 2'd0, 4'b1000);
      tick(1); check_output("up3_f1", S_UP, 2'd1, 4'b1000);
      tick(4); check_output("up3_f2", S_UP, 2'd2, 4'b1000);
      tick(3); check_output("up3_last_move", S_UP, 2'd2, 4'b1000);
      tick(1); check_output("up3_arrive", S_DOOR, 2'd3, 4'b0000);
      tick(3); check_output("up3_idle", S_IDLE, 2'd3, 4'b0000);

      // Down to floor 2, then hold the door with extra_waiting for 5 cycles.
      call_req = 4'b0100;
      tick(1); call_req = 4'b0000;
      check_output("dn2_latched", S_IDLE, 2'd3, 4'b0100);
      tick(1); check_output("dn2_start", S_DOWN, 2'd3, 4'b0100);
      tick(4); check_output("dn2_arrive", S_DOOR, 2'd2, 4'b0000);
      extra_waiting = 1'b1;
      for (int h = 0; h < 5; h++) begin
         if (h == 2) call_req = 4'b0100;
         tick(1);
         call_req = 4'b0000;
         check_output($sformatf("hold_%0d", h), S_DOOR, 2'd2, 4'b0000);
      end
      extra_waiting = 1'b0;
      tick(1); check_output("release_1", S_DOOR, 2'd2, 4'b0000);
      tick(1); check_output("release_2", S_DOOR, 2'd2, 4'b0000);
      tick(1); check_output("release_closed", S_IDLE, 2'd2, 4'b0000);

      extra_waiting = 1'b1;
      tick(2); check_output("idle_ignores_hold", S_IDLE, 2'd2, 4'b0000);
      extra_waiting = 1'b0;

      // Calls both sides of floor 2 after a downward trip: keep going down first.
      call_req = 4'b1001;
      tick(1); call_req = 4'b0000;
      check_output("pref_latched", S_IDLE, 2'd2, 4'b1001);
      tick(1); check_output("pref_down", S_DOWN, 2'd2, 4'b1001);
      tick(4); check_output("pref_pass_f1", S_DOWN, 2'd1, 4'b1001);
      tick(4); check_output("pref_f0_door", S_DOOR, 2'd0, 4'b1000);
      tick(3); check_output("pref_idle", S_IDLE, 2'd0, 4'b1000);
      tick(1); check_output("pref_reverse_up", S_UP, 2'd0, 4'b1000);
      tick(1);
      reset = 1'b1;
      #1 check_output("reset_mid_travel", S_IDLE, 2'd0, 4'b0000);
      tick(1);
      reset = 1'b0;
      tick(1); check_output("reset_released", S_IDLE, 2'd0, 4'b0000);

      // SCAN: new calls ahead served on the way up, the one behind after reversal.
      call_req = 4'b1000;
      tick(1); call_req = 4'b0000;
      check_output("scan_latched", S_IDLE, 2'd0, 4'b1000);
      tick(5); check_output("scan_f1", S_UP, 2'd1, 4'b1000);
      tick(1); call_req = 4'b0101;
      tick(1); call_req = 4'b0000;
      check_output("scan_new_calls", S_UP, 2'd1, 4'b1101);
      tick(2); check_output("scan_stop_f2", S_DOOR, 2'd2, 4'b1001);
      tick(3); check_output("scan_idle_f2", S_IDLE, 2'd2, 4'b1001);
      tick(1); check_output("scan_resume_up", S_UP, 2'd2, 4'b1001);
      tick(4); check_output("scan_stop_f3", S_DOOR, 2'd3, 4'b0001);
      tick(3); check_output("scan_idle_f3", S_IDLE, 2'd3, 4'b0001);
      tick(1); check_output("scan_reverse", S_DOWN, 2'd3, 4'b0001);
      tick(4); check_output("scan_pass_f2", S_DOWN, 2'd2, 4'b0001);
      tick(4); check_output("scan_pass_f1", S_DOWN, 2'd1, 4'b0001);
      tick(4); check_output("scan_stop_f0", S_DOOR, 2'd0, 4'b0000);
      tick(3); check_output("scan_done", S_IDLE, 2'd0, 4'b0000);

      // Reset between floors 1 and 2, then a normal call right at reset release.
      call_req = 4'b0100;
      tick(1); call_req = 4'b0000;
      tick(1); check_output("abort_start", S_UP, 2'd0, 4'b0100);
      tick(4); check_output("abort_f1", S_UP, 2'd1, 4'b0100);
      tick(2);
      reset = 1'b1;
      #1 check_output("abort_reset", S_IDLE, 2'd0, 4'b0000);
      tick(1);
      reset = 1'b0;
      call_req = 4'b0010;
      tick(1); call_req = 4'b0000;
      check_output("after_abort_latched", S_IDLE, 2'd0, 4'b0010);
      tick(1); check_output("after_abort_up", S_UP, 2'd0, 4'b0010);
      tick(4); check_output("after_abort_f1", S_DOOR, 2'd1, 4'b0000);
      tick(3); check_output("after_abort_idle", S_IDLE, 2'd1, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
